// File: rtl/pipe_scoreboard_if.sv
// ---------------------------------------------------------------------------
// pipe_scoreboard_if
//
// Bundle between the decode stage and the pipeline hazard scoreboard.
//
// Parameters
//   STAGES  in-flight stages tracked after decode (sets the forward-select width)
//   RPORTS  source-operand read ports checked per cycle
//
// Signals (direction seen from the scoreboard, i.e. the slave modport)
//   issue_valid  in   decode presents an instruction
//   issue_wen    in   issued instruction writes a register
//   issue_load   in   issued instruction is a load
//   issue_dest   in   destination register of the issued instruction
//   src_addr     in   source register per port, port p at [5p+4:5p]
//   src_used     in   port p operand is actually read
//   flush        in   kill the instruction being issued this cycle
//   fwd_sel      out  per port, SW bits: 0 = register file, k = stage k-1
//   stall        out  hold decode and PC, bubble into stage 0
//   occupancy    out  count of valid writing entries in flight
// ---------------------------------------------------------------------------
interface pipe_scoreboard_if #(
    parameter int STAGES = 3,
    parameter int RPORTS = 2
);
    localparam int SW = $clog2(STAGES + 1);

    logic                   issue_valid;
    logic                   issue_wen;
    logic                   issue_load;
    logic [4:0]             issue_dest;
    logic [5*RPORTS-1:0]    src_addr;
    logic [RPORTS-1:0]      src_used;
    logic                   flush;
    logic [SW*RPORTS-1:0]   fwd_sel;
    logic                   stall;
    logic [3:0]             occupancy;

    // Decode side.
    modport master (
        output issue_valid, issue_wen, issue_load, issue_dest,
        output src_addr, src_used, flush,
        input  fwd_sel, stall, occupancy
    );

    // Scoreboard side.
    modport slave (
        input  issue_valid, issue_wen, issue_load, issue_dest,
        input  src_addr, src_used, flush,
        output fwd_sel, stall, occupancy
    );
endinterface

// File: rtl/pipe_scoreboard.sv
// ---------------------------------------------------------------------------
// pipe_scoreboard
//
// Tracks the instructions in flight after decode as a shift register of
// {valid, wen, load, dest} entries (stage 0 = EX) and, for every source
// read port, picks the youngest in-flight producer to forward from. If that
// producer is a load whose data is not yet available (stage < LOAD_READY)
// decode is stalled and a bubble is inserted into stage 0.
//
// Parameters
//   STAGES      in-flight stages tracked after decode (1..8)
//   RPORTS      source-operand read ports (1..4)
//   LOAD_READY  first stage whose load result is forwardable (1..STAGES-1)
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-low reset, clears all entries
//   bus          slave side of pipe_scoreboard_if (issue, sources, flush,
//                fwd_sel, stall, occupancy)
//   stall_count  out  32-bit saturating count of stalled cycles; present
//                only when PIPE_SCOREBOARD_STATS_EN is defined
//
// All outputs are combinational functions of the current entries and the
// current inputs; occupancy depends on the entries only.
// ---------------------------------------------------------------------------
module pipe_scoreboard #(
    parameter int STAGES     = 3,
    parameter int RPORTS     = 2,
    parameter int LOAD_READY = 2
) (
    input  logic              clk,
    input  logic              rst,
    pipe_scoreboard_if.slave  bus
`ifdef PIPE_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]       stall_count
`endif
);
    localparam int SW = $clog2(STAGES + 1);

    typedef struct packed {
        logic       valid;
        logic       wen;
        logic       load;
        logic [4:0] dest;
    } entry_t;

    entry_t               stageQ [STAGES];
    entry_t               newEntry;
    logic                 stallAny;
    logic [SW*RPORTS-1:0] fwdSel;
    logic [3:0]           occCount;

    // An entry can feed a port only if it really writes a non-zero register
    // that the port really reads.
    function automatic logic entryMatch(entry_t e, logic [4:0] addr, logic used);
        return e.valid && e.wen && used && (e.dest == addr) && (e.dest != 5'd0);
    endfunction

    // ---------------------------------------------------------------------
    // Hazard detection / forward selection
    // ---------------------------------------------------------------------
    always_comb begin
        logic [SW-1:0] sel;
        logic          blocked;
        // NOTE: every variable written here gets a default first, so no path
        // leaves a value held over from an earlier evaluation (no latch).
        stallAny = 1'b0;
        fwdSel   = '0;
        sel      = '0;
        blocked  = 1'b0;
        for (int p = 0; p < RPORTS; p++) begin
            sel     = '0;
            blocked = 1'b0;
            // Walk oldest to youngest so the youngest match overwrites.
            for (int i = STAGES - 1; i >= 0; i--) begin
                if (entryMatch(stageQ[i], bus.src_addr[p*5 +: 5], bus.src_used[p])) begin
                    sel     = SW'(i + 1);
                    blocked = stageQ[i].load && (i < LOAD_READY);
                end
            end
            // A load that cannot forward yet: stall, and read nothing useful.
            if (blocked) begin
                stallAny = 1'b1;
                sel      = '0;
            end
            fwdSel[p*SW +: SW] = sel;
        end
    end

    // Occupancy counts registered entries only, never the issuing instruction.
    always_comb begin
        occCount = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (stageQ[i].valid && stageQ[i].wen) begin
                occCount = occCount + 4'd1;
            end
        end
    end

    // Flush and stall both turn the issuing instruction into a bubble; flush
    // never touches entries already in flight.
    always_comb begin
        newEntry.valid = bus.issue_valid && !bus.flush && !stallAny;
        newEntry.wen   = bus.issue_wen;
        newEntry.load  = bus.issue_load;
        newEntry.dest  = bus.issue_dest;
    end

    assign bus.fwd_sel   = fwdSel;
    assign bus.stall     = stallAny;
    assign bus.occupancy = occCount;

    // ---------------------------------------------------------------------
    // Entry shift register: stage i -> i+1, last stage retires. With
    // STAGES=1 the shift loop is empty and entry 0 is replaced every cycle.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the entry array is small control state, not a RAM, so the
            // whole of it is reset; a stale valid bit would create a phantom
            // hazard right after reset.
            for (int i = 0; i < STAGES; i++) begin
                stageQ[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage sample its
            // predecessor's old value, which is what makes this a shift.
            stageQ[0] <= newEntry;
            for (int i = 1; i < STAGES; i++) begin
                stageQ[i] <= stageQ[i-1];
            end
        end
    end

`ifdef PIPE_SCOREBOARD_STATS_EN
    // Stalled-cycle counter, saturating at all ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (stallAny && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_pipe_scoreboard
//
// Directed scenarios followed by random traffic. The reference model keeps
// the in-flight instructions as a list tagged with their age in cycles since
// issue; forwarding and stalling are derived from the youngest matching age.
// Inputs change on the falling edge, outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_pipe_scoreboard;
    localparam int STAGES     = 3;
    localparam int RPORTS     = 2;
    localparam int LOAD_READY = 2;
    localparam int SW         = $clog2(STAGES + 1);

    logic clk;
    logic rst;
`ifdef PIPE_SCOREBOARD_STATS_EN
    logic [31:0] stallCount;
`endif

    pipe_scoreboard_if #(.STAGES(STAGES), .RPORTS(RPORTS)) ifc ();

    pipe_scoreboard #(
        .STAGES    (STAGES),
        .RPORTS    (RPORTS),
        .LOAD_READY(LOAD_READY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (ifc)
`ifdef PIPE_SCOREBOARD_STATS_EN
        ,
        .stall_count(stallCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ----------------------------- reference model -------------------------
    typedef struct {
        bit wen;
        bit load;
        int dest;
        int age;
    } inflight_t;

    inflight_t   mdl[$];
    int          expSel[RPORTS];
    bit          expStall;
    int          expOcc;
    logic [31:0] expStallCount;

    int total = 0;
    int bad   = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int srcOf(int p);
        logic [5*RPORTS-1:0] a;
        a = ifc.src_addr;
        return int'(a[p*5 +: 5]);
    endfunction

    task automatic evalModel();
        expStall = 0;
        expOcc   = 0;
        foreach (mdl[k]) if (mdl[k].wen) expOcc++;
        for (int p = 0; p < RPORTS; p++) begin
            int  bestAge;
            bit  bestLoad;
            bestAge  = -1;
            bestLoad = 0;
            foreach (mdl[k]) begin
                if (ifc.src_used[p] && mdl[k].wen && mdl[k].dest != 0 &&
                    mdl[k].dest == srcOf(p) && (bestAge < 0 || mdl[k].age < bestAge)) begin
                    bestAge  = mdl[k].age;
                    bestLoad = mdl[k].load;
                end
            end
            if (bestAge < 0) begin
                expSel[p] = 0;
            end else if (bestLoad && bestAge < LOAD_READY) begin
                expSel[p] = 0;
                expStall  = 1;
            end else begin
                expSel[p] = bestAge + 1;
            end
        end
    endtask

    task automatic checkModel(string tag);
        logic [SW*RPORTS-1:0] fs;
        fs = ifc.fwd_sel;
        for (int p = 0; p < RPORTS; p++) begin
            check($sformatf("%s fwd_sel[%0d]", tag, p), 32'(fs[p*SW +: SW]), 32'(expSel[p]));
        end
        check({tag, " stall"}, 32'(ifc.stall), 32'(expStall));
        check({tag, " occupancy"}, 32'(ifc.occupancy), 32'(expOcc));
`ifdef PIPE_SCOREBOARD_STATS_EN
        check({tag, " stall_count"}, stallCount, expStallCount);
`endif
    endtask

    // Apply one cycle's inputs (called just after a falling edge) and check.
    task automatic drive(string tag, bit v, bit w, bit ld, int dest,
                         int a0, int a1, bit [1:0] used, bit fl);
        logic [9:0] addr;
        addr = {5'(a1), 5'(a0)};
        ifc.issue_valid = v;
        ifc.issue_wen   = w;
        ifc.issue_load  = ld;
        ifc.issue_dest  = 5'(dest);
        ifc.src_addr    = addr;
        ifc.src_used    = used;
        ifc.flush       = fl;
        #1;
        evalModel();
        checkModel(tag);
    endtask

    // Clock edge: age everything, retire past the last stage, add the issue.
    task automatic advance();
        bit        issued;
        inflight_t nxt[$];
        inflight_t e;
        issued = ifc.issue_valid && !ifc.flush && !expStall;
        e.wen  = ifc.issue_wen;
        e.load = ifc.issue_load;
        e.dest = int'(ifc.issue_dest);
        e.age  = 0;
        @(posedge clk);
        if (rst) begin
            foreach (mdl[k]) begin
                if (mdl[k].age + 1 < STAGES) begin
                    inflight_t t;
                    t     = mdl[k];
                    t.age = t.age + 1;
                    nxt.push_back(t);
                end
            end
            if (issued) nxt.push_back(e);
            mdl = nxt;
            if (expStall && expStallCount != 32'hFFFF_FFFF) expStallCount++;
        end
        @(negedge clk);
    endtask

    function automatic int fsel(int p);
        logic [SW*RPORTS-1:0] fs;
        fs = ifc.fwd_sel;
        return int'(fs[p*SW +: SW]);
    endfunction

    // ------------------------------- stimulus ------------------------------
    initial begin
        rst             = 1'b0;
        ifc.issue_valid = 0;
        ifc.issue_wen   = 0;
        ifc.issue_load  = 0;
        ifc.issue_dest  = '0;
        ifc.src_addr    = '0;
        ifc.src_used    = '0;
        ifc.flush       = 0;
        expStallCount   = '0;
        expStall        = 0;

        // Outputs quiet while held in reset, before any clock edge.
        #2;
        check("reset occupancy", 32'(ifc.occupancy), 32'd0);
        check("reset stall", 32'(ifc.stall), 32'd0);
        check("reset fwd_sel", 32'(ifc.fwd_sel), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Producer one cycle ahead forwards from stage 0, then stage 1.
        drive("fwd issue", 1, 1, 0, 8, 0, 0, 2'b00, 0); advance();
        drive("fwd s0", 0, 0, 0, 0, 8, 0, 2'b01, 0);
        check("fwd s0 const", 32'(fsel(0)), 32'd1);
        check("fwd s0 nostall", 32'(ifc.stall), 32'd0);
        advance();
        drive("fwd s1", 0, 0, 0, 0, 8, 0, 2'b01, 0);
        check("fwd s1 const", 32'(fsel(0)), 32'd2);
        advance();
        drive("fwd s2", 0, 0, 0, 0, 8, 0, 2'b01, 0); advance();
        drive("fwd retired", 0, 0, 0, 0, 8, 0, 2'b01, 0);
        check("fwd retired const", 32'(fsel(0)), 32'd0);
        advance();

        // Load-use: stall while the load sits in stages 0..LOAD_READY-1,
        // then forward from stage LOAD_READY.
        drive("ld issue", 1, 1, 1, 9, 0, 0, 2'b00, 0); advance();
        drive("ld s0", 0, 0, 0, 0, 9, 0, 2'b01, 0);
        check("ld s0 stall const", 32'(ifc.stall), 32'd1);
        check("ld s0 sel const", 32'(fsel(0)), 32'd0);
        advance();
        drive("ld s1", 0, 0, 0, 0, 9, 0, 2'b01, 0);
        check("ld s1 stall const", 32'(ifc.stall), 32'd1);
        advance();
        drive("ld ready", 0, 0, 0, 0, 9, 0, 2'b01, 0);
        check("ld ready stall const", 32'(ifc.stall), 32'd0);
        check("ld ready sel const", 32'(fsel(0)), 32'(LOAD_READY + 1));
        advance();
        drive("idle", 0, 0, 0, 0, 0, 0, 2'b00, 0); advance();

        // Two producers of r5: the youngest wins on port 1.
        drive("yw issue a", 1, 1, 0, 5, 0, 0, 2'b00, 0); advance();
        drive("yw issue b", 1, 1, 0, 5, 0, 5, 2'b10, 0); advance();
        drive("yw read", 0, 0, 0, 0, 0, 5, 2'b10, 0);
        check("yw youngest const", 32'(fsel(1)), 32'd1);
        advance();

        // r0 never forwards; unused ports never forward.
        drive("r0 issue", 1, 1, 0, 0, 0, 0, 2'b00, 0); advance();
        drive("r0 read", 1, 1, 0, 6, 0, 0, 2'b01, 0);
        check("r0 sel const", 32'(fsel(0)), 32'd0);
        check("r0 stall const", 32'(ifc.stall), 32'd0);
        advance();
        drive("unused", 0, 0, 0, 0, 6, 6, 2'b00, 0);
        check("unused sel const", 32'(ifc.fwd_sel), 32'd0);
        advance();
        for (int i = 0; i < STAGES; i++) begin
            drive("drain", 0, 0, 0, 0, 0, 0, 2'b00, 0); advance();
        end

        // Flushed issue never enters the pipe.
        drive("flush issue", 1, 1, 0, 7, 0, 0, 2'b00, 1); advance();
        drive("flush read", 0, 0, 0, 0, 7, 0, 2'b01, 0);
        check("flush sel const", 32'(fsel(0)), 32'd0);
        check("flush occ const", 32'(ifc.occupancy), 32'd0);
        advance();

        // Asynchronous reset with three entries in flight and a stall pending.
        drive("rs a", 1, 1, 0, 10, 0, 0, 2'b00, 0); advance();
        drive("rs b", 1, 1, 0, 11, 0, 0, 2'b00, 0); advance();
        drive("rs c", 1, 1, 1, 12, 0, 0, 2'b00, 0); advance();
        drive("rs pre", 0, 0, 0, 0, 12, 11, 2'b11, 0);
        check("rs pre occ const", 32'(ifc.occupancy), 32'd3);
        check("rs pre stall const", 32'(ifc.stall), 32'd1);
        #1 rst = 1'b0;
        #1;
        mdl.delete();
        expStallCount = '0;
        check("rs async occ", 32'(ifc.occupancy), 32'd0);
        check("rs async stall", 32'(ifc.stall), 32'd0);
        check("rs async fwd", 32'(ifc.fwd_sel), 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive("rs held", 1, 1, 0, 3, 12, 11, 2'b11, 0);
        rst = 1'b1;
        drive("rs released", 0, 0, 0, 0, 12, 11, 2'b11, 0); advance();

        // Three stalled cycles from two back-to-back load-use pairs.
        drive("sc ld13", 1, 1, 1, 13, 0, 0, 2'b00, 0); advance();
        drive("sc use13 a", 0, 0, 0, 0, 13, 0, 2'b01, 0); advance();
        drive("sc use13 b", 0, 0, 0, 0, 13, 0, 2'b01, 0); advance();
        drive("sc ld14", 1, 1, 1, 14, 13, 0, 2'b01, 0); advance();
        drive("sc use14", 0, 0, 0, 0, 14, 0, 2'b01, 0); advance();
        drive("sc done", 0, 0, 0, 0, 0, 0, 2'b00, 0);
`ifdef PIPE_SCOREBOARD_STATS_EN
        check("stall_count const", stallCount, 32'd3);
`endif
        advance();

        // Random traffic over a small register set to make hazards common.
        for (int n = 0; n < 400; n++) begin
            drive($sformatf("rnd%0d", n),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
